// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: SPI command decode FSM
// encoding, command byte bit positions and the register file map.
package pwm_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned ADDR_W_DEF  = 6;
    localparam int unsigned ADDR_LIM_DEF = 20;

    // Command byte: [7] = R/W (1 = write), [6] = hl, [ADDR_W-1:0] = address
    localparam int unsigned CMD_RW_BIT = 7;
    localparam int unsigned CMD_HL_BIT = 6;

    typedef enum logic [1:0] {
        S_CMD  = 2'd0,
        S_RD   = 2'd1,
        S_DATA = 2'd2
    } dec_state_t;

    // Register file map (20 mapped addresses, 0..19)
    localparam logic [5:0] REG_CTRL     = 6'd0;
    localparam logic [5:0] REG_STATUS   = 6'd1;
    localparam logic [5:0] REG_PRESCALE = 6'd2;
    localparam logic [5:0] REG_PERIOD   = 6'd3;
    localparam logic [5:0] REG_DUTY0    = 6'd4;
    localparam logic [5:0] REG_DUTY7    = 6'd11;
    localparam logic [5:0] REG_PHASE0   = 6'd12;
    localparam logic [5:0] REG_PHASE7   = 6'd19;

endpackage : pwm_pkg

// File: rtl/instr_decode.sv
// instr_decode: decodes two-byte SPI frames (command byte, data byte) coming
// from the SPI bridge into single-cycle read/write strobes for the PWM
// register file, and returns read data to the bridge transmit byte.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cs_n              synchronised chip select; high aborts the frame
//   byte_sync,data_in received-byte strobe and byte from the bridge
//   data_out          byte shifted out on MISO during the next byte slot
//   read, write       one-cycle register strobes (never both high)
//   addr, hl          register address and byte-lane select
//   data_read         register file read data (combinational from addr)
//   data_write        write data, valid while write is high
//   err               sticky illegal-address flag
//
// Build option: define INSTR_DECODE_ERR_EN to reject addresses >= ADDR_LIMIT
// (strobe suppressed, reads return 8'h00, err set until reset). Without it
// err is tied low and every address is passed through.
module instr_decode
    import pwm_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned ADDR_LIMIT = ADDR_LIM_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic              hl,
    input  logic [7:0]        data_read,
    output logic [7:0]        data_write,
    output logic              err
);

    // Reject out-of-range parameters at elaboration
    if (ADDR_W < 1 || ADDR_W > 6 || ADDR_LIMIT < 1) begin : g_param_check
        $error("instr_decode: ADDR_W must be 1..6 and ADDR_LIMIT >= 1");
    end

    dec_state_t r_state;
    logic       r_rw;
    logic       r_illegal;

    logic              w_frame_byte;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_illegal;

    assign w_frame_byte = byte_sync & ~cs_n;
    assign w_cmd_addr   = data_in[ADDR_W-1:0];

`ifdef INSTR_DECODE_ERR_EN
    assign w_illegal = 32'(w_cmd_addr) >= ADDR_LIMIT;

    // Sticky error: set on any illegal command byte, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (r_state == S_CMD && w_frame_byte && w_illegal) begin
            err <= 1'b1;
        end
    end
`else
    assign w_illegal = 1'b0;
    assign err       = 1'b0;
`endif

    // Frame FSM with registered strobes and datapath outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CMD;
            r_rw       <= 1'b0;
            r_illegal  <= 1'b0;
            data_out   <= 8'h00;
            read       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            hl         <= 1'b0;
            data_write <= 8'h00;
        end else begin
            read  <= 1'b0;
            write <= 1'b0;
            case (r_state)
                S_CMD: begin
                    if (w_frame_byte) begin
                        addr      <= w_cmd_addr;
                        hl        <= data_in[CMD_HL_BIT];
                        r_rw      <= data_in[CMD_RW_BIT];
                        r_illegal <= w_illegal;
                        if (data_in[CMD_RW_BIT]) begin
                            r_state <= S_DATA;
                        end else begin
                            read    <= ~w_illegal;
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    // addr is stable here, so data_read reflects the target
                    data_out <= r_illegal ? 8'h00 : data_read;
                    r_state  <= S_DATA;
                end
                S_DATA: begin
                    if (w_frame_byte) begin
                        if (r_rw && !r_illegal) begin
                            write      <= 1'b1;
                            data_write <= data_in;
                        end
                        r_state <= S_CMD;
                    end
                end
                default: r_state <= S_CMD;
            endcase
            // Chip select deassertion aborts the frame from any state
            if (cs_n) begin
                r_state <= S_CMD;
            end
        end
    end

endmodule : instr_decode

// File: tb/tb_instr_decode.sv
// Directed self-checking bench for instr_decode.
module tb_instr_decode;

    localparam int unsigned ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              cs_n;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic              hl;
    logic [7:0]        data_read;
    logic [7:0]        data_write;
    logic              err;

    logic [7:0] regs [64];

    int n_total = 0;
    int n_bad   = 0;

    instr_decode #(.ADDR_W(ADDR_W), .ADDR_LIMIT(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .hl         (hl),
        .data_read  (data_read),
        .data_write (data_write),
        .err        (err)
    );

    // Register file model: combinational read from addr
    assign data_read = regs[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte for exactly one rising edge; returns at the following
    // falling edge, where the registered response to that byte is visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_in   = b;
        byte_sync = 1'b1;
        @(negedge clk);
        byte_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".data_out"},   32'(data_out),   32'h00);
        check({tag, ".read"},       32'(read),       32'h0);
        check({tag, ".write"},      32'(write),      32'h0);
        check({tag, ".addr"},       32'(addr),       32'h0);
        check({tag, ".hl"},         32'(hl),         32'h0);
        check({tag, ".data_write"}, 32'(data_write), 32'h00);
        check({tag, ".err"},        32'(err),        32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 8'(i * 7 + 1);
        regs[5]  = 8'h3C;
        regs[7]  = 8'h5A;
        regs[25] = 8'h99;

        rst_n = 1'b0; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00;
        idle(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle(2);

        // Write frame 0x83 / 0xA5
        cs_n = 1'b0;
        send_byte(8'h83);
        check("wr.cmd_no_read",  32'(read),  32'h0);
        check("wr.cmd_no_write", 32'(write), 32'h0);
        idle(3);
        send_byte(8'hA5);
        check("wr.write",      32'(write),      32'h1);
        check("wr.addr",       32'(addr),       32'h03);
        check("wr.hl",         32'(hl),         32'h0);
        check("wr.data_write", 32'(data_write), 32'hA5);
        check("wr.read",       32'(read),       32'h0);
        idle(1);
        check("wr.single",     32'(write),      32'h0);
        cs_n = 1'b1;
        idle(3);

        // Read frame 0x45 / 0x00 from addr 5
        cs_n = 1'b0;
        send_byte(8'h45);
        check("rd.read",  32'(read), 32'h1);
        check("rd.addr",  32'(addr), 32'h05);
        check("rd.hl",    32'(hl),   32'h1);
        check("rd.write", 32'(write), 32'h0);
        idle(1);
        check("rd.single",   32'(read),     32'h0);
        check("rd.data_out", 32'(data_out), 32'h3C);
        idle(3);
        send_byte(8'h00);
        check("rd.data_no_write", 32'(write),    32'h0);
        check("rd.data_no_read",  32'(read),     32'h0);
        check("rd.data_out_hold", 32'(data_out), 32'h3C);
        cs_n = 1'b1;
        idle(3);

        // Abort after command byte, stray byte while deselected, new frame
        cs_n = 1'b0;
        send_byte(8'h81);
        idle(1);
        cs_n = 1'b1;
        idle(2);
        send_byte(8'h99);
        check("abort.cs_high_ignored", 32'(write), 32'h0);
        idle(2);
        cs_n = 1'b0;
        send_byte(8'h82);
        check("abort.no_write",   32'(write),      32'h0);
        check("abort.dw_hold",    32'(data_write), 32'hA5);
        idle(3);
        send_byte(8'h11);
        check("abort.new_write",  32'(write),      32'h1);
        check("abort.new_addr",   32'(addr),       32'h02);
        check("abort.new_data",   32'(data_write), 32'h11);
        cs_n = 1'b1;
        idle(3);

        // Reset in the middle of a frame
        cs_n = 1'b0;
        send_byte(8'hC4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_byte(8'h07);
        check("midrst.read", 32'(read), 32'h1);
        check("midrst.addr", 32'(addr), 32'h07);
        check("midrst.hl",   32'(hl),   32'h0);
        idle(1);
        check("midrst.data_out", 32'(data_out), 32'h5A);
        idle(2);
        send_byte(8'h00);
        check("midrst.no_write", 32'(write), 32'h0);
        cs_n = 1'b1;
        idle(3);

        // Two write frames back to back inside one chip select
        cs_n = 1'b0;
        send_byte(8'h81);
        idle(2);
        send_byte(8'h5E);
        check("b2b.w0",    32'(write),      32'h1);
        check("b2b.a0",    32'(addr),       32'h01);
        check("b2b.hl0",   32'(hl),         32'h0);
        check("b2b.d0",    32'(data_write), 32'h5E);
        idle(2);
        send_byte(8'hC3);
        check("b2b.cmd1_no_write", 32'(write), 32'h0);
        idle(2);
        send_byte(8'hF0);
        check("b2b.w1",    32'(write),      32'h1);
        check("b2b.a1",    32'(addr),       32'h03);
        check("b2b.hl1",   32'(hl),         32'h1);
        check("b2b.d1",    32'(data_write), 32'hF0);
        check("b2b.dout_stale", 32'(data_out), 32'h5A);
        cs_n = 1'b1;
        idle(3);

`ifdef INSTR_DECODE_ERR_EN
        check("err.clear_before", 32'(err), 32'h0);
        // Write to addr 21 is illegal
        cs_n = 1'b0;
        send_byte(8'h95);
        idle(2);
        send_byte(8'h77);
        check("err.wr_suppressed", 32'(write),      32'h0);
        check("err.wr_dw_hold",    32'(data_write), 32'hF0);
        check("err.set",           32'(err),        32'h1);
        cs_n = 1'b1;
        idle(3);
        // Read of addr 25 is illegal
        cs_n = 1'b0;
        send_byte(8'h19);
        check("err.rd_suppressed", 32'(read), 32'h0);
        idle(1);
        check("err.rd_zero",  32'(data_out), 32'h00);
        idle(2);
        send_byte(8'h00);
        cs_n = 1'b1;
        idle(3);
        // Legal read afterwards still works, err stays sticky
        cs_n = 1'b0;
        send_byte(8'h05);
        check("err.legal_read", 32'(read), 32'h1);
        idle(1);
        check("err.legal_data", 32'(data_out), 32'h3C);
        check("err.sticky",     32'(err),      32'h1);
        idle(2);
        send_byte(8'h00);
        cs_n = 1'b1;
        idle(3);
`else
        // Without the address check, high addresses pass through
        cs_n = 1'b0;
        send_byte(8'h95);
        idle(2);
        send_byte(8'h77);
        check("hi.wr_write", 32'(write),      32'h1);
        check("hi.wr_addr",  32'(addr),       32'd21);
        check("hi.wr_data",  32'(data_write), 32'h77);
        cs_n = 1'b1;
        idle(3);
        cs_n = 1'b0;
        send_byte(8'h19);
        check("hi.rd_read", 32'(read), 32'h1);
        idle(1);
        check("hi.rd_data", 32'(data_out), 32'h99);
        check("hi.err_low", 32'(err),      32'h0);
        idle(2);
        send_byte(8'h00);
        cs_n = 1'b1;
        idle(3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Strobes must never overlap
    always @(negedge clk) begin
        if (rst_n && read && write) begin
            n_total++;
            n_bad++;
            $display("FAIL strobe_overlap: read=%0b write=%0b required not both", read, write);
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_instr_decode

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Sits directly downstream of the SPI bridge and upstream of the PWM register file.
- Consumes the bridge's per-byte strobe and received byte, and decodes a two-byte SPI frame: a command byte followed by a data byte.
- Issues single-cycle read/write strobes to the register file.
- Returns read data to the bridge's transmit byte so that it is shifted out on MISO during the second byte.

Parameters:
- ADDR_W, 6: register address width; taken from command bits [ADDR_W-1:0]; legal range 1..6.
- ADDR_LIMIT, 20: number of mapped addresses; used only when INSTR_DECODE_ERR_EN is defined.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  asynchronous active-low reset
- cs_n  in  1  SPI chip select, synchronised to clk; high aborts the frame
- byte_sync  in  1  one-clk pulse; data_in holds a complete received byte
- data_in  in  8  byte received from the SPI bridge
- data_out  out  8  byte the SPI bridge transmits on the next byte slot
- read  out  1  one-cycle register read strobe
- write  out  1  one-cycle register write strobe
- addr  out  ADDR_W  register address, valid while read or write is high
- hl  out  1  byte-lane select from command bit 6 (1 = high byte)
- data_read  in  8  register file read data, combinational from addr
- data_write  out  8  write data, valid while write is high
- err  out  1  sticky illegal-address flag (optional feature)

Behaviour:
- Reset is asynchronous on rst_n low.
  - State goes to S_CMD.
  - All outputs are 0: data_out, read, write, addr, hl, data_write, err.
- Command byte layout:
  - bit7 = R/W (1 = write, 0 = read)
  - bit6 = hl
  - bits[ADDR_W-1:0] = addr
  - When ADDR_W < 6, bits [5:ADDR_W] are ignored.
- State machine has three states: S_CMD, S_RD, S_DATA.
- S_CMD, on byte_sync with cs_n low:
  - Latch addr, hl and the R/W bit.
  - Read command: next state S_RD.
  - Write command: next state S_DATA.
- S_RD lasts exactly one cycle:
  - read = 1.
  - data_out <= data_read, captured on that edge.
  - Next state S_DATA.
  - Read latency: read is high 1 cycle after the command byte_sync; data_out is updated 2 cycles after it.
- S_DATA, on byte_sync with cs_n low:
  - Write command: on the next cycle write = 1 for exactly 1 cycle, and data_write = data_in captured at that byte_sync.
  - Read command: the data byte is discarded and no strobe is issued.
  - Next state S_CMD in both cases.
- data_out holds its value until the next read capture.
- Write commands leave data_out unchanged; the master sees stale data during the second byte of a write.
- addr and hl hold their values between strobes.
- data_write is updated only on a write.
- byte_sync while cs_n is high is ignored.
- cs_n high in any state forces S_CMD on the next edge.
  - A pending write is dropped.
  - A read strobe already high completes its single cycle.
- byte_sync arriving in the S_RD cycle is impossible; the bridge needs at least 8 sclk periods per byte. It is ignored if it does occur.
- A third byte within one cs_n frame is treated as a new command byte.
- read and write are never high in the same cycle.

Optional Feature:
- Macro: INSTR_DECODE_ERR_EN.
- With the macro defined, an access with addr >= ADDR_LIMIT is illegal:
  - The write strobe is suppressed.
  - The read strobe is suppressed and data_out <= 8'h00.
  - err is set and stays 1 until reset.
- Without the macro, err is tied to 0, all addresses are passed through, and ADDR_LIMIT is unused.

Decomposition:
- Shared package pwm_pkg holds:
  - state encoding: S_CMD = 2'd0, S_RD = 2'd1, S_DATA = 2'd2
  - command bit positions: CMD_RW_BIT = 7, CMD_HL_BIT = 6
  - ADDR_W default
  - register address constants for the register file
- No sub-module: a single FSM plus output registers.

Test Plan:
- Write frame: cs_n low, bytes 8'h83 then 8'hA5 -> one cycle after the second byte_sync: write = 1, addr = 3, hl = 0, data_write = 8'hA5; read stays 0.
- Read frame: data_read = 8'h3C at addr 5, bytes 8'h45 then 8'h00 -> read = 1 one cycle after the first byte_sync, hl = 1, addr = 5; data_out = 8'h3C one cycle later; no write.
- Abort: byte 8'h81, then cs_n high before the second byte -> no write; a new frame 8'h82/8'h11 gives write with addr = 2, data_write = 8'h11.
- Reset mid-frame: rst_n low after the command byte -> all outputs 0, state S_CMD; the following frame decodes correctly.
- Back-to-back: two write frames in one cs_n frame (4 bytes) -> two write pulses, addr/data matching each pair.
- ERR_EN build, ADDR_LIMIT = 20: write to addr 21 -> no write strobe, err = 1 and sticky; read of addr 25 -> data_out = 8'h00, no read strobe.
